// File: rtl/mem_ctrl_if.sv
// Byte-wide RAM owner bus: ifetch request, LSB request and external RAM port.
// The requesters and the RAM sit on the master side; mem_ctrl takes the slave side.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_en;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  logic              lsb_en;
  logic              lsb_rw;
  logic [ADDR_W-1:0] lsb_addr;
  logic [2:0]        lsb_len;
  logic [31:0]       lsb_w_data;
  logic              lsb_done;
  logic [31:0]       lsb_r_data;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport master (
    output if_en, if_addr, lsb_en, lsb_rw, lsb_addr, lsb_len, lsb_w_data, mem_din,
    input  if_done, if_data, lsb_done, lsb_r_data, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  if_en, if_addr, lsb_en, lsb_rw, lsb_addr, lsb_len, lsb_w_data, mem_din,
    output if_done, if_data, lsb_done, lsb_r_data, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Sole owner of the byte-wide RAM port: arbitrates ifetch vs LSB and splits
// each access into little-endian byte cycles against a 1-cycle-latency RAM.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int IF_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       rollback,
  input  logic       io_buffer_full,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] IF_N = 3'(IF_LEN);

  state_t            state_q, state_nxt;
  logic              own_lsb_q, own_lsb_nxt;
  logic              rw_q, rw_nxt;
  logic [2:0]        len_q, len_nxt;
  logic [2:0]        cnt_q, cnt_nxt;
  logic              wr_q, wr_nxt;
  logic [ADDR_W-1:0] mem_a_q, mem_a_nxt;
  logic [7:0]        mem_dout_q, mem_dout_nxt;
  logic [31:0]       if_data_q, if_data_nxt;
  logic [31:0]       lsb_r_data_q, lsb_r_data_nxt;
  logic              pend_vld_q;

  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [31:0]       wdata_q, wdata_nxt;
  logic [31:0]       rbuf_q, rbuf_nxt;
  logic [7:0]        pend_byte_q;

  logic [2:0]        req_len;
  logic [7:0]        byte_in;
  logic              stall;

  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > 3'd4) ? 3'd4 : len;
  endfunction

  function automatic logic [7:0] get_lane(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_lane(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[{lane, 3'b000} +: 8] = b;
    return w;
  endfunction

  assign req_len = clamp_len(bus.lsb_len);
  // The byte returned during the first paused cycle is parked and used on resume,
  // since mem_a is held and the RAM keeps returning the next address meanwhile.
  assign byte_in = pend_vld_q ? pend_byte_q : bus.mem_din;
  assign stall   = rw_q && (addr_q[17:16] == 2'b11) && io_buffer_full;

  always_comb begin
    state_nxt      = state_q;
    own_lsb_nxt    = own_lsb_q;
    rw_nxt         = rw_q;
    len_nxt        = len_q;
    cnt_nxt        = cnt_q;
    wr_nxt         = wr_q;
    mem_a_nxt      = mem_a_q;
    mem_dout_nxt   = mem_dout_q;
    if_data_nxt    = if_data_q;
    lsb_r_data_nxt = lsb_r_data_q;
    addr_nxt       = addr_q;
    wdata_nxt      = wdata_q;
    rbuf_nxt       = rbuf_q;

    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (bus.lsb_en) begin
            own_lsb_nxt = 1'b1;
            rw_nxt      = bus.lsb_rw;
            addr_nxt    = bus.lsb_addr;
            len_nxt     = req_len;
            wdata_nxt   = bus.lsb_w_data;
            cnt_nxt     = 3'd0;
            rbuf_nxt    = 32'd0;
            if (req_len == 3'd0) begin
              state_nxt = DONE;
            end else begin
              state_nxt    = BUSY;
              mem_a_nxt    = bus.lsb_addr;
              mem_dout_nxt = bus.lsb_w_data[7:0];
              wr_nxt       = bus.lsb_rw;
            end
          end else if (bus.if_en && !rollback) begin
            own_lsb_nxt = 1'b0;
            rw_nxt      = 1'b0;
            addr_nxt    = bus.if_addr;
            len_nxt     = IF_N;
            cnt_nxt     = 3'd0;
            rbuf_nxt    = 32'd0;
            state_nxt   = BUSY;
            mem_a_nxt   = bus.if_addr;
            wr_nxt      = 1'b0;
          end
        end

        BUSY: begin
          if (!own_lsb_q && rollback) begin
            state_nxt = IDLE;
            wr_nxt    = 1'b0;
          end else if (rw_q) begin
            if (!stall) begin
              if (cnt_q == len_q - 3'd1) begin
                state_nxt = DONE;
                wr_nxt    = 1'b0;
              end else begin
                cnt_nxt      = cnt_q + 3'd1;
                mem_a_nxt    = addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);
                mem_dout_nxt = get_lane(wdata_q, 2'(cnt_q + 3'd1));
              end
            end
          end else begin
            // Byte for address addr+cnt-1 arrives now and lands in lane cnt-1.
            if (cnt_q != 3'd0) begin
              rbuf_nxt = put_lane(rbuf_q, 2'(cnt_q - 3'd1), byte_in);
            end
            if (cnt_q == len_q) begin
              state_nxt = DONE;
              if (own_lsb_q) lsb_r_data_nxt = rbuf_nxt;
              else           if_data_nxt    = rbuf_nxt;
            end else begin
              cnt_nxt = cnt_q + 3'd1;
              if (cnt_q + 3'd1 < len_q) begin
                mem_a_nxt = addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);
              end
            end
          end
        end

        DONE: begin
          state_nxt = IDLE;
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_lsb_q    <= 1'b0;
      rw_q         <= 1'b0;
      len_q        <= 3'd0;
      cnt_q        <= 3'd0;
      wr_q         <= 1'b0;
      mem_a_q      <= '0;
      mem_dout_q   <= 8'd0;
      if_data_q    <= 32'd0;
      lsb_r_data_q <= 32'd0;
      pend_vld_q   <= 1'b0;
    end else begin
      own_lsb_q    <= own_lsb_nxt;
      rw_q         <= rw_nxt;
      len_q        <= len_nxt;
      cnt_q        <= cnt_nxt;
      wr_q         <= wr_nxt;
      mem_a_q      <= mem_a_nxt;
      mem_dout_q   <= mem_dout_nxt;
      if_data_q    <= if_data_nxt;
      lsb_r_data_q <= lsb_r_data_nxt;
      pend_vld_q   <= !rdy;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_nxt;
    wdata_q <= wdata_nxt;
    rbuf_q  <= rbuf_nxt;
    if (!rdy && !pend_vld_q) pend_byte_q <= bus.mem_din;
  end

  assign bus.if_done    = (state_q == DONE) && !own_lsb_q && !rollback;
  assign bus.lsb_done   = (state_q == DONE) && own_lsb_q;
  assign bus.if_data    = if_data_q;
  assign bus.lsb_r_data = lsb_r_data_q;
  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = mem_dout_q;
  assign bus.mem_wr     = wr_q && rdy && !stall && (state_q == BUSY);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: ifetch, LSB loads/stores, arbitration, IO stall,
// rollback, asynchronous reset mid-store and rdy pause mid-read.
module tb_mem_ctrl;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic rollback = 1'b0;
  logic io_buffer_full = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_ctrl #(.ADDR_W(ADDR_W), .IF_LEN(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .rollback      (rollback),
    .io_buffer_full(io_buffer_full),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // External RAM with one cycle of read latency.
  logic [7:0] ram [logic [31:0]];
  logic       loaded = 1'b0;
  always @(posedge clk) begin
    logic [7:0] rd;
    if (!loaded) begin
      ram[32'h100] = 8'h13;
      ram[32'h101] = 8'h00;
      ram[32'h102] = 8'h00;
      ram[32'h103] = 8'h00;
      ram[32'h200] = 8'h80;
      loaded = 1'b1;
    end
    rd = ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
    if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    bus.mem_din <= rd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic lsb_req(input logic rw, input logic [31:0] a, input logic [2:0] len,
                         input logic [31:0] wd);
    bus.lsb_en = 1'b1;
    bus.lsb_rw = rw;
    bus.lsb_addr = a;
    bus.lsb_len = len;
    bus.lsb_w_data = wd;
  endtask

  initial begin
    logic [31:0] wv;
    logic [7:0]  rb;
    bus.if_en = 1'b0;
    bus.if_addr = '0;
    bus.lsb_en = 1'b0;
    bus.lsb_rw = 1'b0;
    bus.lsb_addr = '0;
    bus.lsb_len = 3'd0;
    bus.lsb_w_data = 32'd0;

    // Reset state
    #3;
    chk("rst_if_done", bus.if_done, 0);
    chk("rst_if_data", bus.if_data, 0);
    chk("rst_lsb_done", bus.lsb_done, 0);
    chk("rst_lsb_r_data", bus.lsb_r_data, 0);
    chk("rst_mem_dout", bus.mem_dout, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    #7 rst = 1'b1;

    // 1: ifetch alone from 0x100
    cyc();
    bus.if_en = 1'b1; bus.if_addr = 32'h100; #1;
    chk("t1_c0_mem_a", bus.mem_a, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc(); #1;
      chk("t1_mem_wr", bus.mem_wr, 0);
      if (i <= 4) chk("t1_mem_a", bus.mem_a, 32'h100 + 32'(i - 1));
      chk("t1_if_done", bus.if_done, (i == 6) ? 1 : 0);
    end
    chk("t1_if_data", bus.if_data, 32'h0000_0013);
    cyc(); bus.if_en = 1'b0; #1;
    chk("t1_done_pulse", bus.if_done, 0);

    // 2: simultaneous requests, LB 0x200 wins
    cyc();
    lsb_req(1'b0, 32'h200, 3'd1, 32'd0);
    bus.if_en = 1'b1; bus.if_addr = 32'h100; #1;
    cyc(); #1;
    chk("t2_mem_a", bus.mem_a, 32'h200);
    cyc(); #1;
    chk("t2_c2_lsb_done", bus.lsb_done, 0);
    cyc(); #1;
    chk("t2_c3_lsb_done", bus.lsb_done, 1);
    chk("t2_lsb_r_data", bus.lsb_r_data, 32'h0000_0080);
    chk("t2_c3_if_done", bus.if_done, 0);
    cyc(); bus.lsb_en = 1'b0; #1;
    chk("t2_c4_lsb_done", bus.lsb_done, 0);
    cyc(); #1;
    chk("t2_if_start_a", bus.mem_a, 32'h100);
    for (int i = 6; i <= 10; i++) begin
      cyc(); #1;
      chk("t2_if_done", bus.if_done, (i == 10) ? 1 : 0);
    end
    chk("t2_if_data", bus.if_data, 32'h0000_0013);
    cyc(); bus.if_en = 1'b0; #1;

    // 3: SW 0xDEADBEEF to 0x1000, then read it back
    cyc();
    wv = 32'hDEAD_BEEF;
    lsb_req(1'b1, 32'h1000, 3'd4, wv); #1;
    for (int i = 1; i <= 4; i++) begin
      cyc(); #1;
      chk("t3_mem_wr", bus.mem_wr, 1);
      chk("t3_mem_a", bus.mem_a, 32'h1000 + 32'(i - 1));
      chk("t3_mem_dout", bus.mem_dout, wv[8*(i-1) +: 8]);
      chk("t3_lsb_done_early", bus.lsb_done, 0);
    end
    cyc(); #1;
    chk("t3_lsb_done", bus.lsb_done, 1);
    chk("t3_wr_off", bus.mem_wr, 0);
    cyc(); bus.lsb_en = 1'b0; #1;
    cyc();
    lsb_req(1'b0, 32'h1000, 3'd4, 32'd0); #1;
    for (int i = 1; i <= 6; i++) begin
      cyc(); #1;
      chk("t3_lw_done", bus.lsb_done, (i == 6) ? 1 : 0);
    end
    chk("t3_lw_data", bus.lsb_r_data, 32'hDEAD_BEEF);
    cyc(); bus.lsb_en = 1'b0; #1;

    // 4: SB to IO space with io_buffer_full for 3 cycles
    cyc();
    lsb_req(1'b1, 32'h30000, 3'd1, 32'h9988_7741);
    io_buffer_full = 1'b1; #1;
    for (int i = 1; i <= 3; i++) begin
      cyc(); #1;
      chk("t4_stall_wr", bus.mem_wr, 0);
      chk("t4_stall_done", bus.lsb_done, 0);
    end
    cyc(); io_buffer_full = 1'b0; #1;
    chk("t4_mem_wr", bus.mem_wr, 1);
    chk("t4_mem_dout", bus.mem_dout, 32'h41);
    chk("t4_mem_a", bus.mem_a, 32'h30000);
    cyc(); #1;
    chk("t4_lsb_done", bus.lsb_done, 1);
    cyc(); bus.lsb_en = 1'b0; #1;
    rb = ram.exists(32'h30000) ? ram[32'h30000] : 8'h00;
    chk("t4_ram_byte", rb, 32'h41);

    // 5: rollback at C3 of an ifetch, LB accepted at C4
    cyc();
    bus.if_en = 1'b1; bus.if_addr = 32'h100; #1;
    cyc(); #1;
    cyc(); #1;
    cyc(); rollback = 1'b1; bus.if_en = 1'b0; #1;
    chk("t5_c3_if_done", bus.if_done, 0);
    cyc(); rollback = 1'b0;
    lsb_req(1'b0, 32'h200, 3'd1, 32'd0); #1;
    chk("t5_c4_if_done", bus.if_done, 0);
    cyc(); #1;
    chk("t5_mem_a", bus.mem_a, 32'h200);
    cyc(); #1;
    chk("t5_c6_lsb_done", bus.lsb_done, 0);
    cyc(); #1;
    chk("t5_c7_lsb_done", bus.lsb_done, 1);
    chk("t5_lsb_r_data", bus.lsb_r_data, 32'h0000_0080);
    chk("t5_c7_if_done", bus.if_done, 0);
    cyc(); bus.lsb_en = 1'b0; #1;

    // 5b: if_en with rollback in IDLE is not taken
    cyc();
    bus.if_en = 1'b1; bus.if_addr = 32'h100; rollback = 1'b1; #1;
    cyc(); rollback = 1'b0; #1;
    chk("t5b_mem_a_held", bus.mem_a, 32'h200);
    for (int i = 2; i <= 7; i++) begin
      cyc(); #1;
      chk("t5b_if_done", bus.if_done, (i == 7) ? 1 : 0);
    end
    cyc(); bus.if_en = 1'b0; #1;

    // 6a: reset after two bytes of a SW, then a fresh LW
    cyc();
    lsb_req(1'b1, 32'h1000, 3'd4, 32'h1122_3344); #1;
    cyc(); #1;
    chk("t6_b0_dout", bus.mem_dout, 32'h44);
    cyc(); #1;
    chk("t6_b1_dout", bus.mem_dout, 32'h33);
    cyc(); rst = 1'b0; bus.lsb_en = 1'b0; #1;
    chk("t6_rst_mem_a", bus.mem_a, 0);
    chk("t6_rst_mem_wr", bus.mem_wr, 0);
    chk("t6_rst_mem_dout", bus.mem_dout, 0);
    chk("t6_rst_lsb_done", bus.lsb_done, 0);
    chk("t6_rst_lsb_r_data", bus.lsb_r_data, 0);
    chk("t6_rst_if_data", bus.if_data, 0);
    cyc(); rst = 1'b1; #1;
    chk("t6_no_done_a", bus.lsb_done, 0);
    cyc(); #1;
    chk("t6_no_done_b", bus.lsb_done, 0);
    cyc();
    lsb_req(1'b0, 32'h1000, 3'd4, 32'd0); #1;
    for (int i = 1; i <= 6; i++) begin
      cyc(); #1;
      chk("t6_lw_done", bus.lsb_done, (i == 6) ? 1 : 0);
    end
    chk("t6_lw_data", bus.lsb_r_data, 32'hDEAD_3344);
    cyc(); bus.lsb_en = 1'b0; #1;

    // 6b: rdy low for two cycles in the middle of an ifetch
    cyc();
    bus.if_en = 1'b1; bus.if_addr = 32'h1000; #1;
    cyc(); #1;
    cyc(); #1;
    cyc(); rdy = 1'b0; #1;
    chk("t6b_c3_mem_a", bus.mem_a, 32'h1002);
    cyc(); #1;
    chk("t6b_c4_mem_a", bus.mem_a, 32'h1002);
    chk("t6b_c4_if_done", bus.if_done, 0);
    cyc(); rdy = 1'b1; #1;
    for (int i = 5; i <= 8; i++) begin
      if (i > 5) begin cyc(); #1; end
      chk("t6b_if_done", bus.if_done, (i == 8) ? 1 : 0);
    end
    chk("t6b_if_data", bus.if_data, 32'hDEAD_3344);
    cyc(); bus.if_en = 1'b0; #1;
    cyc(); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
